// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the multichannel TDC back-end.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FLUSH
    } tdc_state_e;

    function automatic int unsigned fine_w(input int unsigned nr_taps);
        return $clog2(nr_taps + 2);
    endfunction

    function automatic int unsigned ch_w(input int unsigned nr_ch);
        return (nr_ch > 1) ? $clog2(nr_ch) : 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned nr_taps, input int unsigned nr_ch);
        return fine_w(nr_taps) + $clog2(nr_ch);
    endfunction

    // Record fields are sized for the largest supported configuration;
    // the top slices each field down to its own port width.
    localparam int unsigned REC_CH_W     = 8;
    localparam int unsigned REC_COARSE_W = 32;
    localparam int unsigned REC_FINE_W   = 8;

    typedef struct packed {
        logic [REC_CH_W-1:0]     ch;
        logic [REC_COARSE_W-1:0] coarse;
        logic [REC_FINE_W-1:0]   fine;
        logic                    avg;
    } tdc_rec_t;

endpackage

// File: rtl/tdc_therm_encoder.sv
// Single-channel thermometer-to-binary encoder: counts leading ones from tap 0.
// Optional bubble filter enabled by macro TDC_BUBBLE_FIX_EN.
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int unsigned NR_TAPS = 16
) (
    input  logic [NR_TAPS:0]             taps,
    output logic [fine_w(NR_TAPS)-1:0]   fine
);

    localparam int unsigned FINE_W = fine_w(NR_TAPS);

    logic [NR_TAPS:0] clean;

`ifdef TDC_BUBBLE_FIX_EN
    // Interior taps take a 3-tap majority vote; the two end taps pass through.
    always_comb begin
        clean = taps;
        for (int i = 1; i < NR_TAPS; i++) begin
            clean[i] = (taps[i-1] & taps[i]) | (taps[i] & taps[i+1]) | (taps[i-1] & taps[i+1]);
        end
    end
`else
    assign clean = taps;
`endif

    logic run;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        fine = '0;
        run  = 1'b1;
        for (int i = 0; i <= NR_TAPS; i++) begin
            if (run && clean[i]) fine = fine + FINE_W'(1);
            else                 run  = 1'b0;
        end
    end

endmodule

// File: rtl/tdc_multichannel_encoder.sv
// Multichannel TDC back-end: coarse counter, per-channel capture, round-robin
// record arbitration, averaging mode, show-ahead output FIFO and delay-trim shift chain.
module tdc_multichannel_encoder
    import tdc_pkg::*;
#(
    parameter int unsigned NR_CH         = 4,
    parameter int unsigned NR_TAPS       = 16,
    parameter int unsigned GATES_IN_CELL = 3,
    parameter int unsigned COARSE_W      = 12,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                                   sclk,
    input  logic                                   R,
    input  logic                                   start,
    input  logic                                   avg_mode,
    input  logic [NR_CH-1:0]                       hit,
    input  logic [NR_CH*(NR_TAPS+1)-1:0]           taps,
    input  logic                                   cfg_en,
    input  logic                                   sdata,
    output logic [NR_CH*NR_TAPS*GATES_IN_CELL-1:0] delay_ctrl,
    output logic                                   dout_valid,
    input  logic                                   dout_ready,
    output logic [ch_w(NR_CH)-1:0]                 dout_ch,
    output logic [COARSE_W-1:0]                    dout_coarse,
    output logic [fine_w(NR_TAPS)-1:0]             dout_fine,
    output logic                                   dout_avg,
    output logic                                   busy,
    output logic                                   timeout,
    output logic                                   ovf
);

    localparam int unsigned TAP_W  = NR_TAPS + 1;
    localparam int unsigned FINE_W = fine_w(NR_TAPS);
    localparam int unsigned CH_W   = ch_w(NR_CH);
    localparam int unsigned SUM_W  = sum_w(NR_TAPS, NR_CH);
    localparam int unsigned DC_W   = NR_CH * NR_TAPS * GATES_IN_CELL;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

    // ---------------- delay-control shift chain ----------------
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge R) begin
        if (!R)          delay_ctrl <= '0;
        else if (cfg_en) delay_ctrl <= {delay_ctrl[DC_W-2:0], sdata};
    end

    // ---------------- fine encoders ----------------
    logic [FINE_W-1:0] fine_code [NR_CH];

    for (genvar c = 0; c < NR_CH; c++) begin : g_enc
        tdc_therm_encoder #(.NR_TAPS(NR_TAPS)) u_enc (
            .taps (taps[c*TAP_W +: TAP_W]),
            .fine (fine_code[c])
        );
    end

    // ---------------- state ----------------
    tdc_state_e          state_q, state_d;
    logic [COARSE_W-1:0] cnt_q;
    logic [NR_CH-1:0]    seen_q, pend_q;
    logic                avg_q, avg_pend_q, ovf_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [COARSE_W-1:0] ch_coarse_q [NR_CH];
    logic [FINE_W-1:0]   ch_fine_q   [NR_CH];

    logic             armed, cnt_max, capture, avg_done;
    logic [NR_CH-1:0] cap_mask, arb_clr;

    assign armed    = (state_q == ST_ARMED);
    assign cnt_max  = &cnt_q;
    // The saturation edge ends the window: hits arriving on it are discarded.
    assign capture  = armed && !cnt_max;
    assign cap_mask = hit & ~seen_q & {NR_CH{capture}};
    assign avg_done = avg_q && (|cap_mask) && (&(seen_q | cap_mask));

    // ---------------- round-robin arbiter ----------------
    logic            arb_valid;
    logic [CH_W-1:0] arb_ch;

    always_comb begin
        arb_valid = 1'b0;
        arb_ch    = '0;
        for (int i = 0; i < NR_CH; i++) begin
            if (!arb_valid && pend_q[rr_ptr_q + CH_W'(i)]) begin
                arb_valid = 1'b1;
                arb_ch    = rr_ptr_q + CH_W'(i);
            end
        end
    end

    assign arb_clr = arb_valid ? (NR_CH'(1) << arb_ch) : '0;

    // ---------------- record build ----------------
    logic [SUM_W-1:0]  fine_sum;
    logic [FINE_W-1:0] avg_fine;
    tdc_rec_t          push_rec;
    logic              push;

    always_comb begin
        fine_sum = '0;
        for (int c = 0; c < NR_CH; c++) fine_sum = fine_sum + SUM_W'(ch_fine_q[c]);
    end

    assign avg_fine = FINE_W'(fine_sum >> $clog2(NR_CH));

    always_comb begin
        push_rec = '0;
        if (avg_pend_q) begin
            push_rec.coarse = REC_COARSE_W'(ch_coarse_q[0]);
            push_rec.fine   = REC_FINE_W'(avg_fine);
            push_rec.avg    = 1'b1;
        end else begin
            push_rec.ch     = REC_CH_W'(arb_ch);
            push_rec.coarse = REC_COARSE_W'(ch_coarse_q[arb_ch]);
            push_rec.fine   = REC_FINE_W'(ch_fine_q[arb_ch]);
        end
    end

    // A start in the same cycle discards whatever was still pending.
    assign push = (arb_valid || avg_pend_q) && !start;

    // ---------------- FSM ----------------
    always_ff @(posedge sclk or negedge R) begin
        if (!R) state_q <= ST_IDLE;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_ARMED;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_ARMED: if ((&seen_q) || cnt_max) state_d = ST_FLUSH;
                ST_FLUSH: if (pend_q == '0 && !avg_pend_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        timeout = (state_q == ST_ARMED) && cnt_max;
    end

    // ---------------- FIFO control ----------------
    tdc_rec_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fifo_cnt_q;
    logic             fifo_full, pop, wr_en, drop;

    assign fifo_full = (fifo_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign dout_valid = (fifo_cnt_q != '0);
    assign pop   = dout_valid && dout_ready;
    assign wr_en = push && (!fifo_full || pop);
    assign drop  = push && fifo_full && !pop;

    // ---------------- measurement datapath ----------------
    always_ff @(posedge sclk or negedge R) begin
        if (!R) begin
            cnt_q      <= '0;
            seen_q     <= '0;
            pend_q     <= '0;
            avg_q      <= 1'b0;
            avg_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            rr_ptr_q   <= '0;
            for (int c = 0; c < NR_CH; c++) begin
                ch_coarse_q[c] <= '0;
                ch_fine_q[c]   <= '0;
            end
        end else if (start) begin
            cnt_q      <= '0;
            seen_q     <= '0;
            pend_q     <= '0;
            avg_q      <= avg_mode;
            avg_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (capture) cnt_q <= cnt_q + COARSE_W'(1);
            seen_q     <= seen_q | cap_mask;
            pend_q     <= (pend_q & ~arb_clr) | (avg_q ? '0 : cap_mask);
            avg_pend_q <= avg_done;
            if (drop)      ovf_q    <= 1'b1;
            if (arb_valid) rr_ptr_q <= arb_ch + CH_W'(1);
            for (int c = 0; c < NR_CH; c++) begin
                if (cap_mask[c]) begin
                    ch_coarse_q[c] <= cnt_q;
                    ch_fine_q[c]   <= fine_code[c];
                end
            end
        end
    end

    assign ovf = ovf_q;

    // ---------------- FIFO storage ----------------
    // NOTE: the small record memory is reset so dout fields read 0 out of reset.
    always_ff @(posedge sclk or negedge R) begin
        if (!R) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (wr_en) begin
                fifo_mem[wr_ptr_q] <= push_rec;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({wr_en, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    tdc_rec_t head;
    assign head        = fifo_mem[rd_ptr_q];
    assign dout_ch     = head.ch[CH_W-1:0];
    assign dout_coarse = head.coarse[COARSE_W-1:0];
    assign dout_fine   = head.fine[FINE_W-1:0];
    assign dout_avg    = head.avg;

    logic unused_rec_pad;
    assign unused_rec_pad = ^{head.ch[REC_CH_W-1:CH_W],
                              head.coarse[REC_COARSE_W-1:COARSE_W],
                              head.fine[REC_FINE_W-1:FINE_W]};

endmodule

// File: tb/tb_tdc_multichannel_encoder.sv
// Directed self-checking bench for tdc_multichannel_encoder (default parameters).
module tb_tdc_multichannel_encoder;

    localparam int NR_CH    = 4;
    localparam int NR_TAPS  = 16;
    localparam int TAP_W    = NR_TAPS + 1;
    localparam int GIC      = 3;
    localparam int COARSE_W = 12;
    localparam int FINE_W   = 5;
    localparam int CH_W     = 2;
    localparam int DC_W     = NR_CH * NR_TAPS * GIC;

    logic                      sclk, R, start, avg_mode, cfg_en, sdata, dout_ready;
    logic [NR_CH-1:0]          hit;
    logic [NR_CH*TAP_W-1:0]    taps;
    logic [DC_W-1:0]           delay_ctrl;
    logic                      dout_valid, dout_avg, busy, timeout, ovf;
    logic [CH_W-1:0]           dout_ch;
    logic [COARSE_W-1:0]       dout_coarse;
    logic [FINE_W-1:0]         dout_fine;

    int checks = 0;
    int errors = 0;

    tdc_multichannel_encoder dut (
        .sclk        (sclk),
        .R           (R),
        .start       (start),
        .avg_mode    (avg_mode),
        .hit         (hit),
        .taps        (taps),
        .cfg_en      (cfg_en),
        .sdata       (sdata),
        .delay_ctrl  (delay_ctrl),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_ch     (dout_ch),
        .dout_coarse (dout_coarse),
        .dout_fine   (dout_fine),
        .dout_avg    (dout_avg),
        .busy        (busy),
        .timeout     (timeout),
        .ovf         (ovf)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(negedge sclk);
    endtask

    function automatic logic [TAP_W-1:0] therm(input int n);
        logic [TAP_W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_fine(input int c, input int n);
        taps[c*TAP_W +: TAP_W] = therm(n);
    endtask

    task automatic pulse_start(input logic mode);
        avg_mode = mode;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        avg_mode = 1'b0;
    endtask

    task automatic do_reset();
        R = 1'b0;
        hit = '0; start = 1'b0; cfg_en = 1'b0; sdata = 1'b0; avg_mode = 1'b0;
        dout_ready = 1'b0; taps = '0;
        cycle(); cycle();
        R = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        R = 1'b1; start = 1'b0; avg_mode = 1'b0; hit = '0; taps = '0;
        cfg_en = 1'b0; sdata = 1'b0; dout_ready = 1'b0;
        cycle(); cycle();
        cfg_en = 1'b1; sdata = 1'b1;
        repeat (3) cycle();
        cfg_en = 1'b0; sdata = 1'b0;
        pulse_start(1'b0);
        cycle();
        hit = 4'b0001; set_fine(0, 3);
        cycle();
        hit = '0;
        cycle();
        R = 1'b0;
        #1;
        checks++; if (delay_ctrl !== '0) begin errors++; $display("FAIL rst_delay_ctrl got %0h exp 0", delay_ctrl); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %0b exp 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", ovf); end
        checks++; if (dout_coarse !== '0) begin errors++; $display("FAIL rst_dout_coarse got %0d exp 0", dout_coarse); end
        checks++; if (dout_fine !== '0) begin errors++; $display("FAIL rst_dout_fine got %0d exp 0", dout_fine); end
        checks++; if ({dout_ch, dout_avg} !== '0) begin errors++; $display("FAIL rst_dout_ch_avg got %0h exp 0", {dout_ch, dout_avg}); end
        cycle();
        R = 1'b1;
        repeat (3) cycle();
        checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort got valid %0b busy %0b exp 0 0", dout_valid, busy); end
    endtask

    task automatic test_shift();
        logic [DC_W-1:0] exp_dc;
        do_reset();
        exp_dc = '0;
        exp_dc[2:0] = 3'b101;
        cfg_en = 1'b1;
        sdata = 1'b1; cycle();
        sdata = 1'b0; cycle();
        sdata = 1'b1; cycle();
        cfg_en = 1'b0; sdata = 1'b0;
        cycle(); cycle();
        checks++; if (delay_ctrl !== exp_dc) begin errors++; $display("FAIL shift_chain got %0h exp %0h", delay_ctrl, exp_dc); end
    endtask

    task automatic test_basic_capture();
        do_reset();
        pulse_start(1'b0);
        repeat (4) cycle();
        hit = 4'b0100; set_fine(2, 5);
        cycle();
        hit = '0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %0b exp 0", dout_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy); end
        cycle();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", dout_valid); end
        checks++; if (dout_ch !== 2'd2) begin errors++; $display("FAIL basic_ch got %0d exp 2", dout_ch); end
        checks++; if (dout_coarse !== 12'd4) begin errors++; $display("FAIL basic_coarse got %0d exp 4", dout_coarse); end
        checks++; if (dout_fine !== 5'd5) begin errors++; $display("FAIL basic_fine got %0d exp 5", dout_fine); end
        checks++; if (dout_avg !== 1'b0) begin errors++; $display("FAIL basic_avg got %0b exp 0", dout_avg); end
        dout_ready = 1'b1;
        cycle();
        dout_ready = 1'b0;
        repeat (3) cycle();
        checks++; if (dout_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_pending got valid %0b busy %0b exp 0 1", dout_valid, busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dout_ready = 1'b1;
        pulse_start(1'b0);
        repeat (2) cycle();
        hit = 4'b1111;
        for (int c = 0; c < NR_CH; c++) set_fine(c, c + 1);
        cycle();
        hit = '0;
        for (int i = 0; i < NR_CH; i++) begin
            cycle();
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp 1", i, dout_valid); end
            checks++; if (dout_ch !== CH_W'(i)) begin errors++; $display("FAIL b2b_ch[%0d] got %0d exp %0d", i, dout_ch, i); end
            checks++; if (dout_coarse !== 12'd2) begin errors++; $display("FAIL b2b_coarse[%0d] got %0d exp 2", i, dout_coarse); end
            checks++; if (dout_fine !== FINE_W'(i + 1)) begin errors++; $display("FAIL b2b_fine[%0d] got %0d exp %0d", i, dout_fine, i + 1); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %0b exp 1", i, busy); end
        end
        cycle();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b exp 0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b exp 0", busy); end
        dout_ready = 1'b0;
    endtask

    task automatic test_averaging();
        do_reset();
        pulse_start(1'b1);
        repeat (9) cycle();
        hit = 4'b1111;
        for (int c = 0; c < NR_CH; c++) set_fine(c, c + 4);
        cycle();
        hit = '0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL avg_early got %0b exp 0", dout_valid); end
        cycle();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL avg_valid got %0b exp 1", dout_valid); end
        checks++; if (dout_ch !== 2'd0) begin errors++; $display("FAIL avg_ch got %0d exp 0", dout_ch); end
        checks++; if (dout_coarse !== 12'd9) begin errors++; $display("FAIL avg_coarse got %0d exp 9", dout_coarse); end
        checks++; if (dout_fine !== 5'd5) begin errors++; $display("FAIL avg_fine got %0d exp 5", dout_fine); end
        checks++; if (dout_avg !== 1'b1) begin errors++; $display("FAIL avg_flag got %0b exp 1", dout_avg); end
        dout_ready = 1'b1;
        cycle();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL avg_single got %0b exp 0", dout_valid); end
        repeat (3) cycle();
        checks++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL avg_done got valid %0b busy %0b exp 0 0", dout_valid, busy); end
        dout_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        dout_ready = 1'b0;
        for (int m = 0; m < 2; m++) begin
            pulse_start(1'b0);
            cycle();
            hit = 4'b1111;
            for (int c = 0; c < NR_CH; c++) set_fine(c, (m == 0) ? c + 1 : 9);
            cycle();
            hit = '0;
            repeat (6) cycle();
            if (m == 0) begin
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_first got %0b exp 0", ovf); end
            end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", ovf); end
        dout_ready = 1'b1;
        for (int i = 0; i < NR_CH; i++) begin
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d] got %0b exp 1", i, dout_valid); end
            checks++; if (dout_ch !== CH_W'(i)) begin errors++; $display("FAIL ovf_ch[%0d] got %0d exp %0d", i, dout_ch, i); end
            checks++; if (dout_fine !== FINE_W'(i + 1)) begin errors++; $display("FAIL ovf_fine[%0d] got %0d exp %0d", i, dout_fine, i + 1); end
            checks++; if (dout_coarse !== 12'd1) begin errors++; $display("FAIL ovf_coarse[%0d] got %0d exp 1", i, dout_coarse); end
            cycle();
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b exp 0", dout_valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", ovf); end
        dout_ready = 1'b0;
    endtask

    task automatic test_bubble();
        logic [4:0] exp_fine;
`ifdef TDC_BUBBLE_FIX_EN
        exp_fine = 5'd5;
`else
        exp_fine = 5'd4;
`endif
        do_reset();
        pulse_start(1'b0);
        cycle();
        hit = 4'b0001;
        taps[0 +: TAP_W] = 17'h0002F;
        cycle();
        hit = '0;
        cycle();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bubble_valid got %0b exp 1", dout_valid); end
        checks++; if (dout_fine !== exp_fine) begin errors++; $display("FAIL bubble_fine got %0d exp %0d", dout_fine, exp_fine); end
        checks++; if (dout_coarse !== 12'd1) begin errors++; $display("FAIL bubble_coarse got %0d exp 1", dout_coarse); end
    endtask

    task automatic test_timeout();
        int  e;
        logic found;
        do_reset();
        dout_ready = 1'b1;
        pulse_start(1'b0);
        e = 0;
        found = 1'b0;
        while (!found && e < 5000) begin
            cycle();
            e++;
            if (timeout === 1'b1) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL timeout_seen got %0b exp 1 (cycle budget expired)", found); end
        checks++; if (e != 4095) begin errors++; $display("FAIL timeout_edge got %0d exp 4095", e); end
        cycle();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %0b exp 0", timeout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_flush got %0b exp 1", busy); end
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got %0b exp 0", busy); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL timeout_norec got %0b exp 0", dout_valid); end
        dout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_basic_capture();
        test_back_to_back();
        test_averaging();
        test_overflow();
        test_bubble();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
